spi_slave_sync: RTL
===================

Name: spi_slave_sync

Overview:
- Next-generation SPI slave IO block, clocked entirely from the fabric clock.
- The SPI pins sclk, cs and mosi are oversampled and synchronised; there is no logic on the sclk net.
- Each frame is LEN_IN command bits in on mosi, then LEN_OUT response bits out on miso, both MSB-first.
- Adds all four SPI modes, a validated rx handshake, tx capture, abort detection and back-to-back frames. It sits between the board SPI pins and the register/command logic.

Parameters:
- LEN_IN, 16, mosi bits received per frame (1..64)
- LEN_OUT, 16, miso bits transmitted per frame (1..64)
- CPOL, 0, sclk idle level (0 = idle low)
- CPHA, 0, 0 = sample on leading edge / drive on trailing; 1 = drive on leading / sample on trailing

Ports:
- clk  input  1  system clock; must be >= 8x sclk frequency
- rst  input  1  asynchronous reset, active-high
- sclk  input  1  SPI clock from master, asynchronous to clk
- cs  input  1  chip select, active-low, asynchronous
- mosi  input  1  master-out data, asynchronous
- miso  output  1  slave-out data
- rx_data  output  LEN_IN  last complete received word
- rx_valid  output  1  one-clk pulse when rx_data updates
- tx_data  input  LEN_OUT  response word; captured on the rx_valid cycle
- tx_done  output  1  one-clk pulse when the last tx bit has been sampled by the master
- frame_err  output  1  one-clk pulse when cs rises mid-frame
- busy  output  1  high while a frame is in progress (bit counter != 0)

Behaviour:
- Input synchronisation:
  - sclk, cs and mosi each pass through a 2-FF synchroniser, then a registered previous-value stage.
  - Edge detect: rise = cur & ~prev; fall = ~cur & prev.
  - Edge mapping: lead_edge = rise if CPOL=0, else fall; trail_edge is the opposite edge.
  - sample_edge = lead_edge if CPHA=0, else trail_edge; drive_edge is the other one.
  - Edges count only while the synchronised cs is low.
- Reset values (async, rst high):
  - miso=0, rx_data=0, rx_valid=0, tx_done=0, frame_err=0, busy=0.
  - Bit counter=0, shift registers=0, synchroniser flops = idle values (sclk=CPOL, cs=1, mosi=0).
- Bit counter:
  - Width $clog2(LEN_IN+LEN_OUT+1). Increments on each sample_edge.
  - After sample edge number LEN_IN+LEN_OUT it returns to 0.
- State machine:
  - IDLE: cs high or counter=0; miso=0.
  - RX: counter 1..LEN_IN-1.
  - TX: counter LEN_IN..LEN_IN+LEN_OUT-1.
- RX:
  - On each sample_edge in IDLE/RX, rx_shift <= {rx_shift[LEN_IN-2:0], mosi_sync}.
  - On sample edge number LEN_IN:
    - rx_data <= the completed word.
    - rx_valid pulses on the next clk cycle (3 clk after the raw sclk edge reaches the synchroniser input).
    - tx_shift <= tx_data is sampled on the rx_valid cycle.
- TX:
  - On each drive_edge while in TX: miso <= tx_shift MSB, tx_shift shifts left.
  - First TX drive_edge: CPHA=0 uses the trailing edge of bit LEN_IN; CPHA=1 uses the leading edge of bit LEN_IN+1.
  - Sample edge number LEN_IN+LEN_OUT pulses tx_done on the next clk cycle; counter returns to 0.
- Back-to-back frames: if cs stays low after wrap, the next sample_edge starts a new frame. No cs toggle is required.
- Abort:
  - Synchronised cs rises while counter != 0: counter <= 0, frame_err pulses 1 clk, miso <= 0.
  - rx_data is unchanged if fewer than LEN_IN bits were received.
  - tx_done does not pulse.
- cs rising with counter=0: no pulse.
- cs falling: no action except enabling edge counting. Glitch-free data is the master's responsibility.
- Simultaneous cs rise and sample_edge in the same clk cycle: abort wins and the edge is ignored.
- rx_valid, tx_done and frame_err are mutually exclusive per cycle.
- LEN_OUT edge case: minimum is 1; there is no zero-length TX.
- No combinational path from any SPI pin to any output.

Test Plan:
- Reset check: rst pulse mid-frame (after 5 sample edges) -> all outputs 0 within the rst-high cycle. Then send 0xA5C3 with tx_data=0x1234 -> frame completes correctly, proving no residue.
- Mode 0: clk 100 MHz, sclk 5 MHz, mosi 0xA5C3, tx_data=0x1234 (LEN_IN=LEN_OUT=16).
  - rx_valid pulses once, 3 clk after sample edge 16, with rx_data=0xA5C3.
  - Master captures 0x1234 on miso over edges 17..32; tx_done pulses once; busy falls.
- Modes 1, 2 and 3 (CPOL/CPHA sweep): repeat the mode 0 frame -> identical rx_data/miso results.
  - miso transitions only on drive edges; sampled value stable ±2 clk around each sample edge.
- Back-to-back: two frames 0x0001, 0xFFFF with cs held low, tx_data changing to 0xBEEF before the second rx_valid.
  - Two rx_valid pulses with the correct words.
  - Second response = 0xBEEF.
- Abort: cs raised after 9 mosi bits -> frame_err pulses once, no rx_valid, rx_data keeps the prior value, miso=0. A following full frame works.
- Abort in TX: cs raised after 20 edges -> rx_valid already seen, frame_err pulses, no tx_done, counter reset (busy=0).

Source files
------------

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave oversampled and synchronised into the clk domain (all four SPI modes).
// Ports:
//   clk, rst             fabric clock (>= 8x sclk), asynchronous active-high reset
//   sclk, cs, mosi       raw SPI pins from the master, asynchronous to clk
//   miso                 registered slave-out data
//   rx_data, rx_valid    last complete LEN_IN-bit command word, one-clk update pulse
//   tx_data              LEN_OUT-bit response word, captured on the rx_valid cycle
//   tx_done              one-clk pulse after the master sampled the last response bit
//   frame_err            one-clk pulse when cs rises mid-frame
//   busy                 high while the bit counter is non-zero
module spi_slave_sync #(
    parameter int unsigned LEN_IN  = 16,
    parameter int unsigned LEN_OUT = 16,
    parameter bit          CPOL    = 1'b0,
    parameter bit          CPHA    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclk,
    input  logic               cs,
    input  logic               mosi,
    output logic               miso,
    output logic [LEN_IN-1:0]  rx_data,
    output logic               rx_valid,
    input  logic [LEN_OUT-1:0] tx_data,
    output logic               tx_done,
    output logic               frame_err,
    output logic               busy
);
    localparam int unsigned   CW       = $clog2(LEN_IN + LEN_OUT + 1);
    localparam logic [CW-1:0] RX_LAST  = CW'(LEN_IN - 1);
    localparam logic [CW-1:0] TX_FIRST = CW'(LEN_IN);
    localparam logic [CW-1:0] TX_LAST  = CW'(LEN_IN + LEN_OUT - 1);

    typedef enum logic [1:0] {IDLE, RX, TX} state_t;

    logic               sclk_s1_q, sclk_s2_q, sclk_p_q;
    logic               cs_s1_q, cs_s2_q, cs_p_q;
    logic               mosi_s1_q, mosi_s2_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LEN_IN-1:0]  rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [LEN_OUT-1:0] tx_shift_q, tx_shift_d;
    logic               miso_q, miso_d;
    logic               rx_valid_q, rx_valid_d, tx_done_q, tx_done_d, frame_err_q, frame_err_d;
    logic               rise, fall, lead, trail, sample, drive, cs_rise;
    logic [LEN_IN:0]    rx_ext;
    state_t             state;

    assign rise    = sclk_s2_q & ~sclk_p_q;
    assign fall    = ~sclk_s2_q & sclk_p_q;
    assign lead    = CPOL ? fall : rise;
    assign trail   = CPOL ? rise : fall;
    // sclk edges only count while the synchronised select is low
    assign sample  = ~cs_s2_q & (CPHA ? trail : lead);
    assign drive   = ~cs_s2_q & (CPHA ? lead : trail);
    assign cs_rise = cs_s2_q & ~cs_p_q;
    // one spare bit on the left makes the shift work for LEN_IN = 1 too
    assign rx_ext  = {rx_shift_q, mosi_s2_q};

    always_comb begin
        state       = (cs_s2_q || cnt_q == '0) ? IDLE : (cnt_q < TX_FIRST ? RX : TX);
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        // an abort beats a coincident sample edge; the edge is dropped
        if (cs_rise && cnt_q != '0) begin
            cnt_d       = '0;
            frame_err_d = 1'b1;
        end else if (sample) begin
            cnt_d      = (cnt_q == TX_LAST) ? '0 : cnt_q + 1'b1;
            rx_shift_d = (cnt_q < TX_FIRST) ? rx_ext[LEN_IN-1:0] : rx_shift_q;
            rx_data_d  = (cnt_q == RX_LAST) ? rx_ext[LEN_IN-1:0] : rx_data_q;
            rx_valid_d = (cnt_q == RX_LAST);
            tx_done_d  = (cnt_q == TX_LAST);
        end
        // the response word is latched the cycle rx_valid is presented
        tx_shift_d = rx_valid_q ? tx_data : tx_shift_q;
        miso_d     = miso_q;
        if (state == IDLE) begin
            miso_d = 1'b0;
        end else if (drive && state == TX) begin
            miso_d     = tx_shift_q[LEN_OUT-1];
            tx_shift_d = tx_shift_q << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1_q   <= CPOL;
            sclk_s2_q   <= CPOL;
            sclk_p_q    <= CPOL;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_p_q      <= 1'b1;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            tx_shift_q  <= '0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_s1_q   <= sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_p_q    <= sclk_s2_q;
            cs_s1_q     <= cs;
            cs_s2_q     <= cs_s1_q;
            cs_p_q      <= cs_s2_q;
            mosi_s1_q   <= mosi;
            mosi_s2_q   <= mosi_s1_q;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            tx_done_q   <= tx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_done   = tx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = (cnt_q != '0);
endmodule
